spi_slave_cs_responder: RTL and testbench
=========================================

Name: spi_slave_cs_responder

Overview:
- SPI responder (slave) with a single chip select, for the far end of the team's SPI master/CS state-machine pair.
- Oversamples SCLK, CS_n and MOSI in the system clock domain.
- Deserialises MOSI bytes, counts the bytes received in each CS frame, and shifts out MISO bytes supplied through a one-deep TX holding register with a ready/valid handshake.
- Sits behind the board-level SPI pins and in front of the register/command logic.

Parameters:
- SPI_MODE, 0: CPOL,CPHA encoding 0=00, 1=01, 2=10, 3=11.
- SYNC_STAGES, 2: synchroniser depth for SCLK, CS_n and MOSI, minimum 2.

Ports:
- i_clk  in  1  system clock; must be at least 8x the SCLK frequency.
- i_rst_n  in  1  asynchronous active-low reset.
- i_SPI_clk  in  1  SCLK from the master.
- i_SPI_CS_n  in  1  chip select, active low.
- i_SPI_MOSI  in  1  serial data in.
- o_SPI_MISO  out  1  serial data out.
- o_SPI_MISO_en  out  1  pad output enable; 1 while the synchronised CS is low.
- i_TX_Byte  in  8  next byte to send.
- i_TX_DV  in  1  i_TX_Byte valid.
- o_TX_Ready  out  1  holding register empty.
- o_RX_DV  out  1  one-cycle pulse, o_RX_Byte valid.
- o_RX_Byte  out  8  last complete received byte.
- o_RX_count  out  3  bytes completed in the current frame.
- o_TX_Underrun  out  1  one-cycle pulse when a load finds the holding register empty.
- o_Frame_Done  out  1  one-cycle pulse at synchronised CS rise.

Behaviour:
- Clock and reset: one clock (i_clk). Reset is asynchronous and active-low (i_rst_n). All flops use reset.
- Reset values: all outputs 0 except o_TX_Ready=1. State=IDLE. Counters 0. Shift registers 0. Hold register empty. Synchroniser flops preset to idle levels: SCLK=CPOL, CS_n=1, MOSI=0.
- Synchronisation: SYNC_STAGES-flop synchronisers, plus one extra flop on SCLK and CS_n for edge detection. Input-to-event latency is SYNC_STAGES+1 i_clk cycles.
- Edge definitions:
  - Leading edge = synchronised SCLK leaving CPOL. Trailing edge = returning to CPOL.
  - CPHA=0: sample=leading, shift=trailing. CPHA=1: sample=trailing, shift=leading.
  - SCLK edges are ignored unless state=SELECTED.
- State machine:
  - IDLE -> SELECTED on CS fall: clear rx bit count, o_RX_count=0. If CPHA=0, load TX shift from hold and set tx_idx=1; if CPHA=1, set tx_idx=0 and drive MISO=0.
  - SELECTED -> DONE on CS rise.
  - DONE -> IDLE unconditionally after one cycle; o_Frame_Done=1 in DONE.
  - Unused encoding -> IDLE.
- RX path:
  - On each sample edge, shift MOSI in MSB-first and increment the 3-bit count.
  - On the 8th edge (count wraps 7->0), the next cycle has o_RX_Byte=shift value and o_RX_DV=1 for exactly one cycle. o_RX_count increments in the same cycle and saturates at 7.
  - A partial byte at CS rise is discarded with no RX_DV. o_RX_count holds until the next CS fall.
- TX path:
  - MISO = tx_shift[7].
  - On each shift edge: if tx_idx==0, load tx_shift from hold; otherwise shift left. Then tx_idx = tx_idx+1 mod 8.
  - Load with the hold register empty: load 0xFF and pulse o_TX_Underrun.
  - CPHA=0: the trailing edge after a frame's last bit performs a load. A byte consumed this way is discarded and is not replayed in the next frame.
- Handshake:
  - o_TX_Ready = hold register empty.
  - i_TX_DV && o_TX_Ready writes hold on that edge. i_TX_DV while not ready is ignored.
  - A load and a write in the same cycle: load takes the old content; the new byte then occupies hold; Ready=0.
- Boundaries:
  - A CS fall and a sample edge detected in the same cycle: CS fall is processed, the edge is ignored.
  - Reset mid-frame returns everything to the reset values immediately. No Frame_Done is generated.
  - SCLK half-period below 4 i_clk cycles is unsupported.

Decomposition:
- spi_pkg: state encodings (IDLE, SELECTED, DONE); mode-to-CPOL/CPHA helper constants; TX_UNDERRUN_FILL = 8'hFF.
- Sub-module spi_sync_edge: parameterised synchroniser with rise/fall outputs and reset value. Instantiated three times (SCLK, CS_n, MOSI); MOSI uses only the level output.

Test Plan:
- Mode 0, hold=0x3C preloaded, master sends 0xA5 with SCLK = i_clk/8: o_RX_DV pulses once, o_RX_Byte=0xA5, master reads 0x3C, o_RX_count=1, then o_Frame_Done pulses.
- Mode 3, two-byte frame, MOSI 0x12,0x34, TX 0xC0 then 0xDE written on o_TX_Ready: RX bytes 0x12,0x34; master reads 0xC0,0xDE; o_RX_count=2.
- Mode 1, hold empty, 1-byte frame: master reads 0xFF, o_TX_Underrun pulses once.
- Mode 0, CS rises after 5 bits of 0xF0: no o_RX_DV, o_RX_count=0, o_Frame_Done=1; the next frame sending 0x81 receives 0x81.
- Mode 2, reset asserted after 12 bits of a 2-byte frame: all outputs immediately at reset values, o_TX_Ready=1; a following clean frame works.
- Back-to-back frames with 3 i_clk of CS high: o_RX_count clears on the second CS fall, and each frame yields one o_Frame_Done pulse.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encodings and mode helpers for the SPI responder
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SELECTED = 2'd1,
      ST_DONE     = 2'd2
   } state_e;

   localparam logic [7:0] TX_UNDERRUN_FILL = 8'hFF;

   function automatic logic mode_cpol(input int mode);
      return mode[1];
   endfunction

   function automatic logic mode_cpha(input int mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with optional rise/fall detection
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0,
   parameter logic EDGE_EN = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], i_d};
      end
   end

   assign o_level = sync_q[STAGES-1];

   if (EDGE_EN) begin : g_edge
      logic prev_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            prev_q <= RST_VAL;
         end else begin
            prev_q <= sync_q[STAGES-1];
         end
      end

      assign o_rise = o_level & ~prev_q;
      assign o_fall = ~o_level & prev_q;
   end else begin : g_no_edge
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
   end

endmodule

// File: rtl/spi_slave_cs_responder.sv
// rtl/spi_slave_cs_responder.sv - oversampling SPI responder with one-deep TX hold register
module spi_slave_cs_responder
   import spi_pkg::*;
#(
   parameter int SPI_MODE    = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_SPI_clk,
   input  logic       i_SPI_CS_n,
   input  logic       i_SPI_MOSI,
   output logic       o_SPI_MISO,
   output logic       o_SPI_MISO_en,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_DV,
   output logic       o_TX_Ready,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic [2:0] o_RX_count,
   output logic       o_TX_Underrun,
   output logic       o_Frame_Done
);

   localparam logic CPOL = mode_cpol(SPI_MODE);
   localparam logic CPHA = mode_cpha(SPI_MODE);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL), .EDGE_EN(1'b1)) u_sync_sclk (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_SPI_clk),
      .o_level(sclk_lvl), .o_rise(sclk_rise), .o_fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b1)) u_sync_cs (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_SPI_CS_n),
      .o_level(cs_lvl), .o_rise(cs_rise), .o_fall(cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_SPI_MOSI),
      .o_level(mosi_lvl), .o_rise(mosi_rise), .o_fall(mosi_fall)
   );

   logic lead_ev, trail_ev, sample_ev, shift_ev;

   assign lead_ev   = CPOL ? sclk_fall : sclk_rise;
   assign trail_ev  = CPOL ? sclk_rise : sclk_fall;
   assign sample_ev = CPHA ? trail_ev : lead_ev;
   assign shift_ev  = CPHA ? lead_ev : trail_ev;

   state_e     state_q;
   logic [7:0] hold_q, tx_shift_q, rx_shift_q, rx_byte_q;
   logic       hold_full_q, rx_dv_q, underrun_q;
   logic [2:0] tx_idx_q, rx_bits_q, rx_count_q;

   logic       load_en, hold_wr;
   logic [7:0] load_byte, rx_shift_d;

   assign hold_wr    = i_TX_DV && !hold_full_q;
   assign load_en    = (state_q == ST_IDLE && cs_fall && !CPHA) ||
                       (state_q == ST_SELECTED && shift_ev && tx_idx_q == 3'd0);
   assign load_byte  = hold_full_q ? hold_q : TX_UNDERRUN_FILL;
   assign rx_shift_d = {rx_shift_q[6:0], mosi_lvl};

   // A load drains the old content first, so a same-cycle write refills the register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
      end else begin
         if (hold_wr) hold_q <= i_TX_Byte;
         if (load_en) hold_full_q <= hold_wr;
         else if (hold_wr) hold_full_q <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         tx_shift_q <= 8'h00;
         tx_idx_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_bits_q  <= 3'd0;
         rx_byte_q  <= 8'h00;
         rx_count_q <= 3'd0;
         rx_dv_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         rx_dv_q    <= 1'b0;
         underrun_q <= load_en && !hold_full_q;
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_q    <= ST_SELECTED;
                  rx_bits_q  <= 3'd0;
                  rx_count_q <= 3'd0;
                  if (!CPHA) begin
                     tx_shift_q <= load_byte;
                     tx_idx_q   <= 3'd1;
                  end else begin
                     tx_shift_q <= 8'h00;
                     tx_idx_q   <= 3'd0;
                  end
               end
            end
            ST_SELECTED: begin
               if (cs_rise) state_q <= ST_DONE;
               if (sample_ev) begin
                  rx_shift_q <= rx_shift_d;
                  rx_bits_q  <= rx_bits_q + 3'd1;
                  if (rx_bits_q == 3'd7) begin
                     rx_byte_q <= rx_shift_d;
                     rx_dv_q   <= 1'b1;
                     if (rx_count_q != 3'd7) rx_count_q <= rx_count_q + 3'd1;
                  end
               end
               if (shift_ev) begin
                  tx_shift_q <= (tx_idx_q == 3'd0) ? load_byte : {tx_shift_q[6:0], 1'b0};
                  tx_idx_q   <= tx_idx_q + 3'd1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_SPI_MISO    = tx_shift_q[7];
   assign o_SPI_MISO_en = ~cs_lvl;
   assign o_TX_Ready    = ~hold_full_q;
   assign o_RX_DV       = rx_dv_q;
   assign o_RX_Byte     = rx_byte_q;
   assign o_RX_count    = rx_count_q;
   assign o_TX_Underrun = underrun_q;
   assign o_Frame_Done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_spi_slave_cs_responder.sv
// tb/tb_spi_slave_cs_responder.sv - scoreboard bench driving one responder per SPI mode
module tb_spi_slave_cs_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic [3:0] cs_n = 4'hF;
   logic [7:0] tx_byte = 8'h00;
   logic       tx_dv = 1'b0;
   int         act = 0;

   logic [3:0] miso, miso_en, tx_ready, rx_dv, underrun, fdone;
   logic [7:0] rx_byte [4];
   logic [2:0] rx_count [4];

   int n_cmp = 0;
   int n_fail = 0;
   int und_cnt = 0;

   logic [7:0]  tx_q [$];
   logic [10:0] exp_rx_q [$];
   int          exp_fd_q [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_cs_responder #(.SPI_MODE(g), .SYNC_STAGES(2)) u_dut (
         .i_clk(clk), .i_rst_n(rst_n),
         .i_SPI_clk(sclk), .i_SPI_CS_n(cs_n[g]), .i_SPI_MOSI(mosi),
         .o_SPI_MISO(miso[g]), .o_SPI_MISO_en(miso_en[g]),
         .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv && (act == g)), .o_TX_Ready(tx_ready[g]),
         .o_RX_DV(rx_dv[g]), .o_RX_Byte(rx_byte[g]), .o_RX_count(rx_count[g]),
         .o_TX_Underrun(underrun[g]), .o_Frame_Done(fdone[g])
      );
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && tx_q.size() > 0 && tx_ready[act]) begin
         tx_byte = tx_q.pop_front();
         tx_dv   = 1'b1;
      end else begin
         tx_dv = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (underrun[act]) und_cnt++;
      if (rx_dv[act]) begin
         if (exp_rx_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_unexpected: got byte 0x%0h count %0d, expected none", rx_byte[act], rx_count[act]);
         end else begin
            check("rx_byte_count", {21'd0, rx_count[act], rx_byte[act]}, {21'd0, exp_rx_q.pop_front()});
         end
      end
      if (fdone[act]) begin
         if (exp_fd_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_done_unexpected: got pulse, expected none");
         end else begin
            check("frame_done_rx_count", {29'd0, rx_count[act]}, exp_fd_q.pop_front());
         end
      end
   end

   task automatic select_mode(input int m);
      act  = m;
      sclk = m[1];
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_tx_taken(input int left);
      for (int i = 0; i < 50 && tx_q.size() > left; i++) @(negedge clk);
      check("tx_hold_written", tx_q.size(), left);
      repeat (2) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [31:0] d, input int nbits, output logic [31:0] rd);
      logic cpol, cpha;
      cpol = act[1];
      cpha = act[0];
      rd   = 32'd0;
      @(negedge clk);
      sclk = cpol;
      mosi = d[31];
      cs_n[act] = 1'b0;
      repeat (8) @(negedge clk);
      for (int b = 0; b < nbits; b++) begin
         if (!cpha) begin
            mosi = d[31-b];
            repeat (4) @(negedge clk);
            rd[31-b] = miso[act];
            sclk = ~cpol;
            repeat (4) @(negedge clk);
            sclk = cpol;
         end else begin
            repeat (4) @(negedge clk);
            sclk = ~cpol;
            mosi = d[31-b];
            repeat (4) @(negedge clk);
            rd[31-b] = miso[act];
            sclk = cpol;
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_release(input int hi);
      cs_n[act] = 1'b1;
      repeat (hi) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {28'd0, tx_ready}, 32'hF);
      check({tag, "_bits"}, {12'd0, miso, miso_en, rx_dv, underrun, fdone}, 32'd0);
      check({tag, "_rxbyte"}, {rx_byte[0], rx_byte[1], rx_byte[2], rx_byte[3]}, 32'd0);
      check({tag, "_rxcount"}, {20'd0, rx_count[0], rx_count[1], rx_count[2], rx_count[3]}, 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          u0;

      repeat (5) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_reset_outputs("post_reset");

      // Mode 0, single byte with a preloaded reply.
      select_mode(0);
      tx_q.push_back(8'h3C);
      wait_tx_taken(0);
      check("m0_ready_low", {31'd0, tx_ready[0]}, 32'd0);
      exp_rx_q.push_back({3'd1, 8'hA5});
      exp_fd_q.push_back(1);
      u0 = und_cnt;
      spi_bits(32'hA500_0000, 8, rd);
      cs_release(20);
      check("m0_miso", {24'd0, rd[31:24]}, 32'h3C);
      check("m0_rx_count", {29'd0, rx_count[0]}, 32'd1);
      check("m0_underrun_after_last_bit", und_cnt - u0, 32'd1);

      // Mode 3, two bytes with the second refilled on ready.
      select_mode(3);
      tx_q.push_back(8'hC0);
      tx_q.push_back(8'hDE);
      wait_tx_taken(1);
      exp_rx_q.push_back({3'd1, 8'h12});
      exp_rx_q.push_back({3'd2, 8'h34});
      exp_fd_q.push_back(2);
      u0 = und_cnt;
      spi_bits(32'h1234_0000, 16, rd);
      cs_release(20);
      check("m3_miso", {16'd0, rd[31:16]}, 32'hC0DE);
      check("m3_rx_count", {29'd0, rx_count[3]}, 32'd2);
      check("m3_no_underrun", und_cnt - u0, 32'd0);
      check("m3_ready_after", {31'd0, tx_ready[3]}, 32'd1);

      // Mode 1, hold empty: reply is the underrun fill.
      select_mode(1);
      exp_rx_q.push_back({3'd1, 8'h5A});
      exp_fd_q.push_back(1);
      u0 = und_cnt;
      spi_bits(32'h5A00_0000, 8, rd);
      cs_release(20);
      check("m1_miso_fill", {24'd0, rd[31:24]}, 32'hFF);
      check("m1_underrun", und_cnt - u0, 32'd1);

      // Mode 0, partial byte is discarded, next frame is clean.
      select_mode(0);
      exp_fd_q.push_back(0);
      spi_bits(32'hF000_0000, 5, rd);
      cs_release(20);
      check("m0_partial_rx_count", {29'd0, rx_count[0]}, 32'd0);
      exp_rx_q.push_back({3'd1, 8'h81});
      exp_fd_q.push_back(1);
      spi_bits(32'h8100_0000, 8, rd);
      cs_release(20);
      check("m0_after_partial_rx_byte", {24'd0, rx_byte[0]}, 32'h81);

      // Mode 2, reset lands in the middle of the second byte.
      select_mode(2);
      tx_q.push_back(8'h77);
      wait_tx_taken(0);
      exp_rx_q.push_back({3'd1, 8'hAB});
      spi_bits(32'hABCD_0000, 12, rd);
      check("m2_pre_reset_en", {31'd0, miso_en[2]}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      cs_n[act] = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      tx_q.push_back(8'h99);
      wait_tx_taken(0);
      exp_rx_q.push_back({3'd1, 8'h42});
      exp_fd_q.push_back(1);
      spi_bits(32'h4200_0000, 8, rd);
      cs_release(20);
      check("m2_miso_after_reset", {24'd0, rd[31:24]}, 32'h99);

      // Mode 0, back-to-back frames separated by three clocks of CS high.
      select_mode(0);
      exp_rx_q.push_back({3'd1, 8'h11});
      exp_fd_q.push_back(1);
      spi_bits(32'h1100_0000, 8, rd);
      cs_release(2);
      exp_rx_q.push_back({3'd1, 8'h22});
      exp_rx_q.push_back({3'd2, 8'h33});
      exp_fd_q.push_back(2);
      spi_bits(32'h2233_0000, 16, rd);
      cs_release(20);

      check("rx_scoreboard_drained", exp_rx_q.size(), 32'd0);
      check("frame_scoreboard_drained", exp_fd_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
